// File: rtl/aes_key_schedule_dec_if.sv
// Bus bundle between the AES-128 decryption controller and the round-key
// generator: key load handshake, status flags and the indexed read port.
interface aes_key_schedule_dec_if;
  logic [127:0] IN_KEY;
  logic         KEY_LOAD;
  logic         BUSY;
  logic         KEY_READY;
  logic         RD_EN;
  logic [3:0]   RD_IDX;
  logic [127:0] OUT_KEY;
  logic         OUT_VALID;

  modport master (
    output IN_KEY, KEY_LOAD, RD_EN, RD_IDX,
    input  BUSY, KEY_READY, OUT_KEY, OUT_VALID
  );

  modport slave (
    input  IN_KEY, KEY_LOAD, RD_EN, RD_IDX,
    output BUSY, KEY_READY, OUT_KEY, OUT_VALID
  );
endinterface

// File: rtl/aes_key_schedule_dec.sv
// AES-128 round-key generator and store: expands one FIPS-197 round key per
// cycle into an 11-entry key file, then serves keys by index with a registered read.

// Forward AES S-box built as GF(2^8) inversion followed by the affine transform.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Inverse as x^254 (maps 0 to 0, as the S-box requires).
  always_comb begin
    x2   = gf_mul(in_i, in_i);
    x3   = gf_mul(x2, in_i);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    out_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end
endmodule

module aes_key_schedule_dec (
  input  logic                         clk,
  input  logic                         rst,
  aes_key_schedule_dec_if.slave        bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] w_q, w_d;
  logic [127:0] rk_q [11];
  logic [127:0] out_key_q, out_key_d;
  logic         out_valid_q, out_valid_d;

  logic [31:0]  w0, w1, w2, w3, rot, sub, t;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_key;
  logic         load_accept, rd_accept;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = w_q;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.in_i(rot[8*g +: 8]), .out_o(sub[8*g +: 8]));
  end

  assign t        = sub ^ {rcon(r_q), 24'h0};
  assign w0_n     = w0 ^ t;
  assign w1_n     = w1 ^ w0_n;
  assign w2_n     = w2 ^ w1_n;
  assign w3_n     = w3 ^ w2_n;
  assign next_key = {w0_n, w1_n, w2_n, w3_n};

  // Loads are ignored mid-expansion; a load in the same cycle as a read wins.
  assign load_accept = bus.KEY_LOAD && (state_q != ST_EXPAND);
  assign rd_accept   = bus.RD_EN && (state_q == ST_DONE) && (bus.RD_IDX <= 4'd10) && !bus.KEY_LOAD;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    w_d         = w_q;
    out_valid_d = rd_accept;
    out_key_d   = rd_accept ? rk_q[bus.RD_IDX] : out_key_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_accept) begin
          state_d = ST_EXPAND;
          r_d     = 4'd1;
          w_d     = bus.IN_KEY;
        end
      end
      ST_EXPAND: begin
        w_d = next_key;
        r_d = r_q + 4'd1;
        if (r_q == 4'd10) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      r_q         <= 4'd0;
      w_q         <= 128'h0;
      out_key_q   <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      w_q         <= w_d;
      out_key_q   <= out_key_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: the key file is not reset; reads are gated by state, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_accept) rk_q[0] <= bus.IN_KEY;
      else if (state_q == ST_EXPAND) rk_q[r_q] <= next_key;
    end
  end

  assign bus.BUSY      = (state_q == ST_EXPAND);
  assign bus.KEY_READY = (state_q == ST_DONE);
  assign bus.OUT_KEY   = out_key_q;
  assign bus.OUT_VALID = out_valid_q;
endmodule

// File: doc/aes_key_schedule_dec.md
# aes_key_schedule_dec

Round-key generator and store for the AES-128 decryption datapath; sits directly upstream of `AES_DECRYPTION_ROUND` and supplies its `IN_KEY`. It loads a 128-bit cipher key and expands it iteratively, one FIPS-197 round key per cycle, into an 11-entry register file. It then serves any round key by index with a one-cycle registered read, so the decryption controller can fetch keys 10 down to 0.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10, 11 round keys).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IN_KEY`  in  128  cipher key; byte 0 = `IN_KEY[127:120]`, FIPS-197 byte order.
- `KEY_LOAD`  in  1  single-cycle start strobe; `IN_KEY` is sampled on the same edge.
- `BUSY`  out  1  expansion in progress.
- `KEY_READY`  out  1  all 11 round keys valid.
- `RD_EN`  in  1  read request.
- `RD_IDX`  in  4  round-key index, 0 to 10.
- `OUT_KEY`  out  128  round key returned by the last accepted read; connects to `AES_DECRYPTION_ROUND.IN_KEY`.
- `OUT_VALID`  out  1  one-cycle pulse marking a new `OUT_KEY`.

## Operation
- States are IDLE, EXPAND and DONE. Reset enters IDLE.
- IDLE to EXPAND when `KEY_LOAD`=1:
  - `rk[0]` <= `IN_KEY`.
  - Round counter `r` <= 1.
  - Working words w0..w3 <= `IN_KEY`.
- Each cycle in EXPAND computes `rk[r]` from the previous key `{w0,w1,w2,w3}`:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - The result is stored in `rk[r]` and becomes the working words; `r` increments.
- RotWord is a 1-byte left rotate. SubWord uses four instances of the existing forward S-box (combinational).
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- EXPAND to DONE on the cycle that writes `rk[10]`.
- `KEY_LOAD` handling by state:
  - In DONE: restarts expansion exactly as from IDLE, and `KEY_READY` drops.
  - In EXPAND: ignored.
- Read acceptance: a read is accepted when `RD_EN`=1, state is DONE, `RD_IDX`<=10 and `KEY_LOAD`=0. The next cycle then gives `OUT_KEY` = `rk[RD_IDX]` and `OUT_VALID`=1.
- Read refusal: a read is refused if not DONE, if `RD_IDX`>10, or if it coincides with `KEY_LOAD` (load wins). On refusal, `OUT_VALID`=0 next cycle and `OUT_KEY` holds its value.
- Read ordering: back-to-back reads are allowed, one per cycle, with no ordering constraint. The decryption sequence reads indices 10, 9, …, 0.
- Reset mid-expansion: abandons the expansion. All outputs go to their reset values and the key file is treated as invalid until a new load completes.

## Timing
- Reset values: `BUSY`=0, `KEY_READY`=0, `OUT_VALID`=0, `OUT_KEY`=128'h0, state IDLE, `r`=0.
- `KEY_LOAD` sampled at edge E0:
  - `BUSY`=1 from E0.
  - `rk[1]`..`rk[10]` written at edges E1..E10.
  - At E10, `BUSY` goes to 0 and `KEY_READY` goes to 1.
  - Expansion latency is therefore 10 cycles from load to ready.
- Read latency is 1 cycle: `RD_EN` sampled at edge E gives `OUT_KEY`/`OUT_VALID` valid after E and held until the next edge.
- `OUT_VALID` is deasserted in every cycle with no accepted read.
- Reload from DONE at edge E0: `KEY_READY`=0 and `BUSY`=1 from E0. Old keys are not readable after E0.
- `BUSY` and `KEY_READY` are never both 1.
- Combinational depth per cycle: one S-box plus the 4-word XOR chain. There is no combinational path from `RD_*` to `OUT_*`.

## Test plan
- **FIPS-197 C.1 key expansion.** Stimulus: reset, then load `IN_KEY`=000102030405060708090a0b0c0d0e0f.
  - `KEY_READY` rises exactly 10 cycles after load.
  - Read idx 1 returns d6aa74fdd2af72fadaa678f1d6ab76fe.
  - Read idx 10 returns 13111d7fe3944a17f307a78b4d2b30c5.
  - Read idx 0 returns the input key.
- **Reverse streaming and round integration.** Stimulus: reads idx 10..0 on 11 consecutive cycles, with `OUT_KEY` driving `AES_DECRYPTION_ROUND`.
  - 11 consecutive `OUT_VALID` pulses in the correct order.
  - The round output for `IN_DATA`=69c4e0d86a7b0430d8cdb78070b4c55a matches the golden model for each key.
- **Second key vector.** Stimulus: load `IN_KEY`=2b7e151628aed2a6abf7158809cf4f3c.
  - Read idx 1 returns a0fafe1788542cb123a339392a6c7605.
  - Read idx 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Illegal and early reads.** Stimulus: `RD_EN` during EXPAND, `RD_IDX`=11 and `RD_IDX`=15 in DONE, and `KEY_LOAD` coinciding with `RD_EN` in DONE.
  - `OUT_VALID`=0 in each case and `OUT_KEY` unchanged.
  - Loads asserted during EXPAND are ignored and `KEY_READY` timing is unchanged.
- **Reset and reload.** Stimulus: assert `rst` at cycle 5 of expansion, then load a new key; separately, reload from DONE with a different key.
  - After reset, all outputs are at reset values.
  - The new key expands correctly with no stale words.
  - On reload from DONE, `KEY_READY` drops on the load edge and the new keys are correct.
